// File: rtl/ssd_pkg.sv
// Shared constants for the 4-digit seven-segment display path.
// Segment patterns are active-high {g,f,e,d,c,b,a}; polarity is applied at the output registers.
package ssd_pkg;

   localparam logic [6:0] SEG_0   = 7'h3F;
   localparam logic [6:0] SEG_1   = 7'h06;
   localparam logic [6:0] SEG_2   = 7'h5B;
   localparam logic [6:0] SEG_3   = 7'h4F;
   localparam logic [6:0] SEG_4   = 7'h66;
   localparam logic [6:0] SEG_5   = 7'h6D;
   localparam logic [6:0] SEG_6   = 7'h7D;
   localparam logic [6:0] SEG_7   = 7'h07;
   localparam logic [6:0] SEG_8   = 7'h7F;
   localparam logic [6:0] SEG_9   = 7'h6F;
   localparam logic [6:0] SEG_A   = 7'h77;
   localparam logic [6:0] SEG_B   = 7'h7C;
   localparam logic [6:0] SEG_C   = 7'h39;
   localparam logic [6:0] SEG_D   = 7'h5E;
   localparam logic [6:0] SEG_E   = 7'h79;
   localparam logic [6:0] SEG_F   = 7'h71;
   localparam logic [6:0] SEG_OFF = 7'h00;

   localparam logic [1:0] DIG3 = 2'd3;
   localparam logic [1:0] DIG2 = 2'd2;
   localparam logic [1:0] DIG1 = 2'd1;
   localparam logic [1:0] DIG0 = 2'd0;

endpackage

// File: rtl/ssd_hex_decode.sv
// Combinational hex digit to active-high gfedcba segment pattern.
module ssd_hex_decode
   import ssd_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_OFF;
      case (code)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
         default: seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/ssd_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display with
// frame-synchronous input latching, per-slot ghost guard and optional leading-zero blanking.
module ssd_scanner
   import ssd_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int SCAN_HZ    = 1_000,
   parameter int GUARD      = 4,
   parameter bit ACTIVE_LOW = 1'b1
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] R3,
   input  logic [3:0] R2,
   input  logic [3:0] R1,
   input  logic [3:0] R0,
   input  logic [3:0] dp_in,
   input  logic       lzs,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame
);

   localparam int DIV = CLK_HZ / SCAN_HZ;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [3:0] AN_OFF_LVL  = ACTIVE_LOW ? 4'hF : 4'h0;
   localparam logic [6:0] SEG_OFF_LVL = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
   localparam logic       DP_OFF_LVL  = ACTIVE_LOW;

   logic [CW-1:0]   cnt;
   logic [1:0]      idx;
   logic [3:0][3:0] dig_sh;
   logic [3:0]      dp_sh;
   logic            lzs_sh;

   logic       tick;
   logic       latch;
   logic       in_guard;
   logic [3:0] blank;
   logic [3:0] cur_code;
   logic [6:0] cur_seg;
   logic [3:0] an_on;
   logic [6:0] seg_on;
   logic       dp_on;

   assign tick     = (cnt == CW'(DIV - 1));
   assign latch    = tick && (idx == DIG0);
   assign in_guard = (GUARD > 0) && (cnt < CW'(GUARD));

   // Scan state and frame-synchronous shadow of the producer inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         idx    <= DIG3;
         dig_sh <= '0;
         dp_sh  <= '0;
         lzs_sh <= 1'b0;
         frame  <= 1'b0;
      end else begin
         cnt   <= tick ? '0 : cnt + 1'b1;
         frame <= latch;
         if (tick)
            idx <= idx - 2'd1;
         if (latch) begin
            dig_sh <= {R3, R2, R1, R0};
            dp_sh  <= dp_in;
            lzs_sh <= lzs;
         end
      end
   end

   // A digit is blanked only while it and every digit to its left are zero.
   always_comb begin
      blank    = '0;
      blank[3] = lzs_sh && (dig_sh[3] == 4'd0);
      blank[2] = blank[3] && (dig_sh[2] == 4'd0);
      blank[1] = blank[2] && (dig_sh[1] == 4'd0);
   end

   assign cur_code = dig_sh[idx];

   ssd_hex_decode u_dec (
      .code (cur_code),
      .seg  (cur_seg)
   );

   always_comb begin
      an_on  = '0;
      seg_on = SEG_OFF;
      dp_on  = 1'b0;
      if (!in_guard) begin
         an_on[idx] = 1'b1;
         if (!blank[idx]) begin
            seg_on = cur_seg;
            dp_on  = dp_sh[idx];
         end
      end
   end

   // Polarity is applied last so the reset level is the inactive level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an  <= AN_OFF_LVL;
         seg <= SEG_OFF_LVL;
         dp  <= DP_OFF_LVL;
      end else begin
         an  <= ACTIVE_LOW ? ~an_on  : an_on;
         seg <= ACTIVE_LOW ? ~seg_on : seg_on;
         dp  <= ACTIVE_LOW ? ~dp_on  : dp_on;
      end
   end

endmodule

// File: tb/tb_ssd_scanner.sv
// Directed bench for ssd_scanner at DIV=4, GUARD=1, active-low outputs.
module tb_ssd_scanner;

   logic       clk;
   logic       rst_n;
   logic [3:0] R3, R2, R1, R0;
   logic [3:0] dp_in;
   logic       lzs;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       frame;

   int n_tests = 0;
   int n_fail  = 0;

   logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   ssd_scanner #(
      .CLK_HZ     (16),
      .SCAN_HZ    (4),
      .GUARD      (1),
      .ACTIVE_LOW (1'b1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .R3    (R3),
      .R2    (R2),
      .R1    (R1),
      .R0    (R0),
      .dp_in (dp_in),
      .lzs   (lzs),
      .an    (an),
      .seg   (seg),
      .dp    (dp),
      .frame (frame)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Walks one full 16-clock frame starting from the sample just after a frame pulse
   // (or just after reset release). Last sample lands on the next frame pulse.
   task automatic check_scan(input logic [3:0] d3, d2, d1, d0, input logic [3:0] dpv,
                             input logic lz, input bit poke, input logic [3:0] pv);
      logic [3:0] d [4];
      logic [3:0] bl;
      logic [6:0] es;
      logic       ed;
      logic [3:0] ea;
      int         k;
      d[3] = d3; d[2] = d2; d[1] = d1; d[0] = d0;
      bl[3] = lz && (d3 == 4'd0);
      bl[2] = bl[3] && (d2 == 4'd0);
      bl[1] = bl[2] && (d1 == 4'd0);
      bl[0] = 1'b0;
      for (int s = 0; s < 4; s++) begin
         k = 3 - s;
         @(negedge clk);
         chk($sformatf("guard%0d", k), {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
         chk($sformatf("frame_lo%0d", k), frame, 1'b0);
         if (poke && s == 1) R0 = pv;
         ea = ~(4'b0001 << k);
         es = bl[k] ? 7'h7F : ~seg_tbl[d[k]];
         ed = bl[k] ? 1'b1 : ~dpv[k];
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("dig%0d_c%0d", k, c), {an, seg, dp}, {ea, es, ed});
         end
      end
      chk("frame_pulse", frame, 1'b1);
   endtask

   initial begin
      int last, nf, cyc;
      rst_n = 1'b0;
      R3 = 4'd5; R2 = 4'd2; R1 = 4'd3; R0 = 4'd3;
      dp_in = 4'b0000;
      lzs   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_out", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
      chk("rst_frame", frame, 1'b0);
      rst_n = 1'b1;

      // First frame shows the reset shadow, then the latched 5233.
      check_scan(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b0, 1'b0, 4'd0);
      R0 = 4'd7;
      check_scan(4'd5, 4'd2, 4'd3, 4'd3, 4'b0000, 1'b0, 1'b0, 4'd0);
      // Mid-frame change of R0 must not tear the current frame.
      check_scan(4'd5, 4'd2, 4'd3, 4'd7, 4'b0000, 1'b0, 1'b1, 4'd8);
      R3 = 4'd0; R2 = 4'd0; R1 = 4'd0; R0 = 4'd7; lzs = 1'b1;
      check_scan(4'd5, 4'd2, 4'd3, 4'd8, 4'b0000, 1'b0, 1'b0, 4'd0);

      // Leading-zero blanking.
      R0 = 4'd0;
      check_scan(4'd0, 4'd0, 4'd0, 4'd7, 4'b0000, 1'b1, 1'b0, 4'd0);
      R1 = 4'd3;
      check_scan(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b1, 1'b0, 4'd0);
      R1 = 4'd0; lzs = 1'b0; dp_in = 4'b0001;
      check_scan(4'd0, 4'd0, 4'd3, 4'd0, 4'b0000, 1'b1, 1'b0, 4'd0);

      // Full decode table on R0 with the R0 decimal point lit.
      for (int v = 1; v < 16; v++) begin
         R0 = 4'(v);
         check_scan(4'd0, 4'd0, 4'd0, 4'(v - 1), 4'b0001, 1'b0, 1'b0, 4'd0);
      end
      R0 = 4'd0; dp_in = 4'b0000; lzs = 1'b1;
      check_scan(4'd0, 4'd0, 4'd0, 4'd15, 4'b0001, 1'b0, 1'b0, 4'd0);

      // Reset in the middle of a digit slot.
      R0 = 4'd9;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_out", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
      chk("midrst_frame", frame, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      check_scan(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b0, 1'b0, 4'd0);

      // Frame period and one-hot anode over 100 frames.
      last = -1; nf = 0; cyc = 0;
      while (nf < 101 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         chk("onehot_an", 32'($onehot0(~an)), 32'd1);
         if (frame) begin
            if (last >= 0) chk("frame_period", 32'(cyc - last), 32'd16);
            last = cyc;
            nf++;
         end
      end
      chk("frame_count", 32'(nf >= 101), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
